// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA timing constants and lock-state encoding shared with the sync generator
package vga_timing_pkg;
    localparam int H_TOTAL_DEF      = 801;
    localparam int V_TOTAL_DEF      = 522;
    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int H_SYNC_START_DEF = 658;
    localparam int V_SYNC_START_DEF = 490;
    localparam int LOCK_FRAMES_DEF  = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lockState_t;
endpackage

// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered-timing outputs of the VGA sync decoder
interface vga_sync_decoder_if;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic [9:0] rx_x;
    logic [9:0] rx_y;
    logic       rx_display;
    logic       locked;
    logic       sync_err;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    modport master (
        output vga_h_sync, vga_v_sync,
        input  rx_x, rx_y, rx_display, locked, sync_err, line_len, frame_lines
    );

    modport slave (
        input  vga_h_sync, vga_v_sync,
        output rx_x, rx_y, rx_display, locked, sync_err, line_len, frame_lines
    );
endinterface

// File: rtl/vga_edge_detect.sv
// rtl/vga_edge_detect.sv - falling-edge pulse on an active-low sync, optional synchronizer (VGA_SYNC_DECODER_SYNC_EN)
module vga_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic syncIn,
    output logic fall
);
    logic syncCur;
    logic syncPrev;

`ifdef VGA_SYNC_DECODER_SYNC_EN
    logic [1:0] syncMeta;

    always_ff @(posedge clk) begin
        if (reset) syncMeta <= 2'b11;
        else       syncMeta <= {syncMeta[0], syncIn};
    end

    assign syncCur = syncMeta[1];
`else
    assign syncCur = syncIn;
`endif

    // Sample starts high so a sync that idles high after reset never fakes a fall
    always_ff @(posedge clk) begin
        if (reset) syncPrev <= 1'b1;
        else       syncPrev <= syncCur;
    end

    assign fall = syncPrev & ~syncCur;
endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel position from VGA syncs and verifies timing; VGA_SYNC_DECODER_SYNC_EN adds input synchronizers
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
    input logic              clk,
    input logic              reset,
    vga_sync_decoder_if.slave vga
);
    localparam int TO_LIMIT = 2 * H_TOTAL;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [9:0] H_TOTAL_L  = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_L  = 10'(V_TOTAL);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE_L = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);
    localparam logic [9:0] V_RELOAD   = 10'(V_SYNC_START);
`ifdef VGA_SYNC_DECODER_SYNC_EN
    localparam logic [9:0] H_RELOAD   = 10'(H_SYNC_START + 2);
`else
    localparam logic [9:0] H_RELOAD   = 10'(H_SYNC_START);
`endif

    logic          hFall, vFall;
    logic [9:0]    rxX, rxY, lineLen, frameLines;
    logic [9:0]    periodCnt, periodNext, frameCnt, frameNext;
    logic [TW-1:0] timeoutCnt, timeoutNext;
    logic [3:0]    goodCnt, goodNext;
    logic          frameErr, firstHPending, syncErr, lockedReg;
    logic          timeout, lineBad, frameBad, errNow;
    lockState_t    lockState;

    vga_edge_detect hEdge (.clk(clk), .reset(reset), .syncIn(vga.vga_h_sync), .fall(hFall));
    vga_edge_detect vEdge (.clk(clk), .reset(reset), .syncIn(vga.vga_v_sync), .fall(vFall));

    always_comb begin
        periodNext  = (periodCnt == 10'd1023) ? periodCnt : periodCnt + 10'd1;
        frameNext   = (hFall && frameCnt != 10'd1023) ? frameCnt + 10'd1 : frameCnt;
        timeoutNext = timeoutCnt + TW'(1);
        goodNext    = goodCnt + 4'd1;
        timeout     = !hFall && (timeoutNext == TW'(TO_LIMIT));
        lineBad     = hFall && (periodNext != H_TOTAL_L);
        frameBad    = vFall && (frameNext != V_TOTAL_L);
        // A bad line landing on the same cycle as the closing v-fall still spoils the frame
        errNow      = frameErr || (lineBad && !firstHPending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxX           <= '0;
            rxY           <= '0;
            lineLen       <= '0;
            frameLines    <= '0;
            periodCnt     <= '0;
            frameCnt      <= '0;
            timeoutCnt    <= '0;
            goodCnt       <= '0;
            frameErr      <= 1'b0;
            firstHPending <= 1'b0;
            syncErr       <= 1'b0;
            lockedReg     <= 1'b0;
            lockState     <= SEARCH;
        end else begin
            syncErr <= 1'b0;

            if (hFall)               rxX <= H_RELOAD;
            else if (rxX == H_LAST)  rxX <= '0;
            else                     rxX <= rxX + 10'd1;

            if (vFall)                        rxY <= V_RELOAD;
            else if (!hFall && rxX == H_LAST) rxY <= (rxY == V_LAST) ? 10'd0 : rxY + 10'd1;

            if (hFall) begin
                lineLen    <= periodNext;
                periodCnt  <= '0;
                timeoutCnt <= '0;
            end else begin
                periodCnt  <= periodNext;
                timeoutCnt <= timeout ? '0 : timeoutNext;
            end

            if (vFall) begin
                frameLines <= frameNext;
                frameCnt   <= '0;
            end else begin
                frameCnt   <= frameNext;
            end

            if (timeout) begin
                if (lockState == LOCKED) syncErr <= 1'b1;
                lockState <= SEARCH;
                lockedReg <= 1'b0;
            end else begin
                case (lockState)
                    SEARCH: begin
                        if (vFall) begin
                            lockState     <= VERIFY;
                            goodCnt       <= '0;
                            frameErr      <= 1'b0;
                            firstHPending <= 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (hFall) begin
                            if (firstHPending) firstHPending <= 1'b0;
                            else if (lineBad)  frameErr      <= 1'b1;
                        end
                        if (vFall) begin
                            frameErr <= 1'b0;
                            if (frameNext == V_TOTAL_L && !errNow) begin
                                goodCnt <= goodNext;
                                if (goodNext >= 4'(LOCK_FRAMES)) begin
                                    lockState <= LOCKED;
                                    lockedReg <= 1'b1;
                                end
                            end else begin
                                goodCnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (lineBad || frameBad) begin
                            syncErr       <= 1'b1;
                            lockState     <= VERIFY;
                            lockedReg     <= 1'b0;
                            goodCnt       <= '0;
                            frameErr      <= 1'b0;
                            firstHPending <= 1'b1;
                        end
                    end
                    default: begin
                        lockState <= SEARCH;
                        lockedReg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign vga.rx_x        = rxX;
    assign vga.rx_y        = rxY;
    assign vga.line_len    = lineLen;
    assign vga.frame_lines = frameLines;
    assign vga.sync_err    = syncErr;
    assign vga.locked      = lockedReg;
    assign vga.rx_display  = lockedReg && (rxX < H_ACTIVE_L) && (rxY < V_ACTIVE_L);
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench: lock, tracking, display window, line/frame/timeout faults, reset
module tb_vga_sync_decoder;
    import vga_timing_pkg::*;

    // Full 801-clock lines, short 6-line frames to keep runtime small
    localparam int HT = 801;
    localparam int VT = 6;
    localparam int HA = 640;
    localparam int VA = 4;
    localparam int HS = 658;
    localparam int VS = 4;
    localparam int LF = 2;
    localparam int BUDGET = 30000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic freeze = 1'b0;
    logic skipLine = 1'b0;
    logic forceHigh = 1'b0;
    int   hCnt = 0, vCnt = 0, vfallCnt = 0;
    int   errPulses = 0, cmpBad = 0;
    logic cmpEn = 1'b0;
    int   checks = 0, errors = 0;
    int   v0, e0, n;

    always #5 clk = ~clk;

    vga_sync_decoder_if vga ();

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vga)
    );

    // Reference sync generator: counters line up with the decoder one cycle after each fall
    always @(posedge clk) begin
        if (reset) begin
            hCnt <= 0;
            vCnt <= 0;
            vfallCnt <= 0;
        end else if (!freeze) begin
            if (hCnt == HT - 1) begin
                hCnt <= 0;
                if (vCnt == VS - 1) vfallCnt <= vfallCnt + 1;
                if (vCnt == VT - 1)               vCnt <= 0;
                else if (skipLine && vCnt == 0)   vCnt <= 2;
                else                              vCnt <= vCnt + 1;
            end else begin
                hCnt <= hCnt + 1;
            end
        end
    end

    assign vga.vga_h_sync = !(hCnt >= HS - 1 && hCnt < HS - 1 + 96) || forceHigh;
    assign vga.vga_v_sync = !((vCnt == VS - 1 && hCnt == HT - 1) || vCnt == VS ||
                              (vCnt == VS + 1 && hCnt != HT - 1));

    always @(negedge clk) begin
        if (vga.sync_err) errPulses <= errPulses + 1;
        if (cmpEn && (vga.rx_x !== 10'(hCnt) || vga.rx_y !== 10'(vCnt))) cmpBad <= cmpBad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic waitPos(input int h, input int v, input string tag);
        int k = 0;
        while (!(hCnt == h && vCnt == v) && k < BUDGET) begin @(negedge clk); k++; end
        check(tag, k < BUDGET, 1);
    endtask

    task automatic waitErr(input string tag);
        int k = 0;
        while (!vga.sync_err && k < BUDGET) begin @(negedge clk); k++; end
        check(tag, k < BUDGET, 1);
    endtask

    task automatic waitLock(input string tag);
        int k = 0;
        while (!vga.locked && k < BUDGET) begin @(negedge clk); k++; end
        check(tag, k < BUDGET, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_x", vga.rx_x, 0);
        check("rst_rx_y", vga.rx_y, 0);
        check("rst_line_len", vga.line_len, 0);
        check("rst_frame_lines", vga.frame_lines, 0);
        check("rst_locked", vga.locked, 0);
        check("rst_sync_err", vga.sync_err, 0);
        check("rst_display", vga.rx_display, 0);
        check("rst_state", dut.lockState, SEARCH);
        reset = 1'b0;

        // Lock on the second v-fall after VERIFY entry: third v-fall overall
        waitLock("lock_initial");
        check("lock_vfalls", vfallCnt, 3);
        check("lock_line_len", vga.line_len, HT);
        check("lock_frame_lines", vga.frame_lines, VT);

        cmpEn = 1'b1;
        repeat (5000) @(negedge clk);
        cmpEn = 1'b0;
        check("track_mismatches", cmpBad, 0);
        check("track_no_err", errPulses, 0);

        waitPos(HA - 1, VA - 1, "wait_disp_edge");
        check("disp_639_3_x", vga.rx_x, HA - 1);
        check("disp_639_3", vga.rx_display, 1);
        @(negedge clk);
        check("disp_640_3", vga.rx_display, 0);
        waitPos(0, VA, "wait_row4");
        check("disp_0_4_y", vga.rx_y, VA);
        check("disp_0_4", vga.rx_display, 0);
        waitPos(0, 0, "wait_row0");
        check("disp_0_0", vga.rx_display, 1);

        // One stretched line of 802 clocks
        waitPos(100, 1, "wait_stretch");
        v0 = vfallCnt;
        e0 = errPulses;
        freeze = 1'b1;
        @(negedge clk);
        freeze = 1'b0;
        waitErr("stretch_err");
        check("stretch_line_len", vga.line_len, HT + 1);
        check("stretch_locked", vga.locked, 0);
        check("stretch_state", dut.lockState, VERIFY);
        @(negedge clk);
        check("stretch_err_1cyc", vga.sync_err, 0);
        waitLock("stretch_relock");
        check("stretch_relock_vfalls", vfallCnt - v0, 2);
        check("stretch_err_count", errPulses - e0, 1);

        // h_sync held high long enough to trip the 2*H_TOTAL timeout
        waitPos(700, 1, "wait_timeout");
        e0 = errPulses;
        forceHigh = 1'b1;
        n = 0;
        while (!vga.sync_err && n < 2000) begin @(negedge clk); n++; end
        check("timeout_err", n < 2000, 1);
        check("timeout_state", dut.lockState, SEARCH);
        check("timeout_locked", vga.locked, 0);
        if (n < 1700) repeat (1700 - n) @(negedge clk);
        forceHigh = 1'b0;
        check("timeout_err_count", errPulses - e0, 1);
        waitLock("timeout_relock");

        // A 5-line frame
        waitPos(10, 0, "wait_skip");
        e0 = errPulses;
        skipLine = 1'b1;
        waitPos(0, 2, "wait_skip_done");
        skipLine = 1'b0;
        waitErr("short_frame_err");
        check("short_frame_lines", vga.frame_lines, VT - 1);
        check("short_frame_state", dut.lockState, VERIFY);
        check("short_frame_locked", vga.locked, 0);
        check("short_frame_line_len", vga.line_len, HT);
        @(negedge clk);
        check("short_frame_err_count", errPulses - e0, 1);

        // Reset mid-line
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_x", vga.rx_x, 0);
        check("mid_rst_rx_y", vga.rx_y, 0);
        check("mid_rst_line_len", vga.line_len, 0);
        check("mid_rst_frame_lines", vga.frame_lines, 0);
        check("mid_rst_locked", vga.locked, 0);
        check("mid_rst_sync_err", vga.sync_err, 0);
        check("mid_rst_display", vga.rx_display, 0);
        check("mid_rst_state", dut.lockState, SEARCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be: H_TOTAL, default 801, clocks per line; V_TOTAL, default 522, lines per frame; H_ACTIVE, default 640, visible pixels; V_ACTIVE, default 480, visible lines.
REQ-002 Parameters SHALL continue: H_SYNC_START, default 658, x value loaded after an h_sync fall; V_SYNC_START, default 490, y value loaded after a v_sync fall; LOCK_FRAMES, default 2, good frames needed to lock.
REQ-003 Ports SHALL be: clk in 1, pixel clock; reset in 1, synchronous active-high reset.
REQ-004 Ports SHALL continue: vga_h_sync in 1, active-low horizontal sync; vga_v_sync in 1, active-low vertical sync.
REQ-005 Ports SHALL continue: rx_x out 10, recovered column; rx_y out 10, recovered row; rx_display out 1, recovered visible area.
REQ-006 Ports SHALL continue: locked out 1, timing verified; sync_err out 1, one-cycle pulse on timing violation.
REQ-007 Ports SHALL continue: line_len out 10, last measured h-fall-to-h-fall period in clocks; frame_lines out 10, last measured lines per frame.

Function
REQ-008 Sync falls SHALL be detected as previous-sample high and current input low; the previous sample SHALL be held in one register per sync.
REQ-009 On an h-fall, rx_x SHALL take H_SYNC_START on the next cycle; otherwise rx_x SHALL increment by one and wrap from H_TOTAL-1 to 0.
REQ-010 rx_y SHALL increment on each rx_x wrap and wrap from V_TOTAL-1 to 0; on a v-fall, rx_y SHALL take V_SYNC_START; a v-fall SHALL take priority over a same-cycle wrap increment.
REQ-011 With the default parameters and same-clock connection to the team's sync generator, rx_x and rx_y SHALL equal the generator counters once locked.
REQ-012 The period counter SHALL count clocks between h-falls, saturate at 1023, and be copied to line_len at each h-fall.
REQ-013 The frame counter SHALL count h-falls between v-falls, saturate at 1023, and be copied to frame_lines at each v-fall.
REQ-014 The lock FSM SHALL have three states: SEARCH, VERIFY and LOCKED.
REQ-015 SEARCH: the first v-fall SHALL move the FSM to VERIFY with good_cnt=0 and the frame error flag cleared.
REQ-016 In VERIFY, any h-fall with a measured period not equal to H_TOTAL SHALL set the frame error flag; the first h-fall after entering VERIFY SHALL be exempt.
REQ-017 At each VERIFY v-fall: if frame_lines equals V_TOTAL and the error flag is clear, good_cnt SHALL increment, else good_cnt SHALL clear; the error flag SHALL then clear.
REQ-018 When good_cnt reaches LOCK_FRAMES, the FSM SHALL move to LOCKED.
REQ-019 In LOCKED, a bad line period or a bad frame count SHALL pulse sync_err for exactly one cycle and return the FSM to VERIFY with good_cnt=0.
REQ-020 In any state, no h-fall for 2*H_TOTAL clocks SHALL force SEARCH, pulse sync_err if the FSM was LOCKED, and clear locked.
REQ-021 locked SHALL be 1 only in LOCKED.
REQ-022 rx_display SHALL be combinational: locked AND rx_x<H_ACTIVE AND rx_y<V_ACTIVE.

Reset
REQ-023 Reset SHALL clear rx_x, rx_y, line_len, frame_lines, sync_err, locked, good_cnt, the error flag and all counters, and SHALL set the state to SEARCH.
REQ-024 Reset SHALL set the sync sample registers to 1, so no fall is detected on the cycle after reset.
REQ-025 Reset mid-frame SHALL discard all partial measurements.

Configuration
REQ-026 With VGA_SYNC_DECODER_SYNC_EN defined, each sync input SHALL pass through a two-flop synchronizer reset to 1 before fall detection, and the rx_x reload value SHALL be H_SYNC_START+2.
REQ-027 With VGA_SYNC_DECODER_SYNC_EN undefined, the inputs SHALL feed fall detection directly and all latencies SHALL be as stated in REQ-008 to REQ-022.

Structure
REQ-028 A shared package vga_timing_pkg SHALL hold the default timing constants (801, 522, 640, 480, 658, 490) and the lock-state encoding, shared with the sync generator.
REQ-029 One sub-module, vga_edge_detect (optional synchronizer plus fall pulse), SHALL be instantiated once per sync input.

Verification
REQ-030 Sync generator connected on the same clock, reset released: locked SHALL rise at the second v-fall after VERIFY entry, after which rx_x and rx_y SHALL equal the generator counters every cycle.
REQ-031 Once locked, rx_x=639, rx_y=479 SHALL give rx_display=1, and rx_x=640 or rx_y=480 SHALL give rx_display=0.
REQ-032 Once locked, one line stretched to 802 clocks SHALL give one sync_err pulse, locked=0, line_len=802, then relock after 2 clean frames.
REQ-033 Once locked, h_sync held high for 1602 clocks SHALL give a sync_err pulse and the SEARCH state; in REQ-020 terms, 2*H_TOTAL = 1602.
REQ-034 Once locked, a frame of 521 lines SHALL give frame_lines=521, a sync_err pulse and VERIFY; reset asserted mid-line SHALL return all outputs to 0 on the next cycle.
